poly_horner_eval: RTL and testbench
===================================

POLY_HORNER_EVAL -- requirements
Module: poly_horner_eval

Interface
REQ-001 Parameter W, default 5, result width; all arithmetic is modulo 2^W.
REQ-002 Parameter XW, default 2, width of operand x.
REQ-003 Parameter YW, default 2, width of offset operand y.
REQ-004 Parameters C3, C2, C1, C0, defaults 8, -4, -5, 1, signed integer coefficients, each reduced modulo 2^W at elaboration.
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 in_valid  input  1  x/y operand pair offered.
REQ-008 in_ready  output  1  block can accept an operand pair.
REQ-009 x  input  XW  unsigned polynomial variable.
REQ-010 y  input  YW  unsigned additive offset.
REQ-011 out_valid  output  1  result available on out.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 out  output  W  result (C3*x^3 + C2*x^2 + C1*x + C0 + y) mod 2^W.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have three states: IDLE, EVAL, DONE.
REQ-016 in_ready SHALL equal (state == IDLE); out_valid SHALL equal (state == DONE); both are registered-state decodes with no combinational path from in_valid or out_ready.
REQ-017 IDLE: on in_valid && in_ready, capture x and y, set acc <= C3, set step <= 0, go to EVAL; otherwise hold.
REQ-018 EVAL, step 0: acc <= (acc*x + C2) mod 2^W; step <= 1.
REQ-019 EVAL, step 1: acc <= (acc*x + C1) mod 2^W; step <= 2.
REQ-020 EVAL, step 2: acc <= (acc*x + C0 + y) mod 2^W; go to DONE.
REQ-021 x and y SHALL be zero-extended to W bits; all products and sums SHALL be truncated to W bits each cycle, with no saturation.
REQ-022 Latency: out_valid SHALL rise exactly 3 clock edges after the accepting edge, so each transaction occupies 4 edges including the accept edge.
REQ-023 DONE: out SHALL hold acc stable while out_valid is high; on out_ready, go to IDLE; otherwise hold indefinitely (backpressure).
REQ-024 out SHALL present acc in every state; its value is meaningful only while out_valid is high.
REQ-025 Inputs x and y SHALL be ignored outside the accepting edge; changes during EVAL or DONE SHALL not affect the result.
REQ-026 Back-to-back operation: the next operand pair SHALL be accepted no earlier than the edge after the DONE->IDLE transition. Peak throughput is one result per 5 cycles.
REQ-027 in_valid asserted while not in IDLE SHALL be ignored, with no capture and no error.
REQ-028 out_ready asserted outside DONE SHALL have no effect.

Reset
REQ-029 While rst_n is low, the block SHALL be held in reset: state = IDLE, acc = 0, step = 0, captured x/y = 0, out = 0, out_valid = 0, busy = 0, and in_ready = 1 once state reads IDLE.
REQ-030 Reset assertion SHALL take effect immediately, without waiting for clk, in any state. An in-flight transaction SHALL be discarded and no out_valid pulse SHALL follow.
REQ-031 After rst_n deasserts, the first possible accept SHALL be the first rising edge on which rst_n is high.

Verification
REQ-032 Defaults, x=1, y=0 accepted, out_ready=1 -> out_valid high 3 edges after accept, out=0, then IDLE on the next edge.
REQ-033 Defaults, x=2, y=1 -> acc sequence 8, 12, 19, then out=8 (40 mod 32).
REQ-034 Defaults, x=3, y=3 -> out=9 (169 mod 32); out_ready held low 10 cycles -> out_valid and out=9 stable throughout; in_ready=0 throughout.
REQ-035 Defaults, x=0, y=2 -> out=3; a second pair x=2, y=1 driven continuously -> accepted only on the edge after the DONE->IDLE transition, and its result is 8.
REQ-036 rst_n pulsed low mid-EVAL after accepting x=3 -> out_valid=0, out=0, and in_ready=1 immediately; no later result appears.
REQ-037 in_valid toggling and x/y changing during EVAL/DONE -> the result matches the captured operands only (x=2, y=1 -> 8).

Source files
------------

// File: rtl/poly_horner_eval.sv
// Cubic polynomial plus offset, evaluated by Horner's rule over three cycles.
// Valid/ready in, valid/ready out; one operand pair in flight at a time.
module poly_horner_eval #(
    parameter int W  = 5,
    parameter int XW = 2,
    parameter int YW = 2,
    parameter int C3 = 8,
    parameter int C2 = -4,
    parameter int C1 = -5,
    parameter int C0 = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out,
    output logic          busy
);

    // Negative coefficients wrap to their two's-complement residue
    localparam logic [W-1:0] K3 = W'(C3);
    localparam logic [W-1:0] K2 = W'(C2);
    localparam logic [W-1:0] K1 = W'(C1);
    localparam logic [W-1:0] K0 = W'(C0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [1:0]     step_q, step_d;
    logic [XW-1:0]  x_q, x_d;
    logic [YW-1:0]  y_q, y_d;

    logic [W-1:0]   x_ext;
    logic [W-1:0]   y_ext;
    logic [W-1:0]   mul;

    assign x_ext = W'(x_q);
    assign y_ext = W'(y_q);
    assign mul   = acc_q * x_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            step_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        step_d  = step_q;
        x_d     = x_q;
        y_d     = y_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d     = x;
                    y_d     = y;
                    acc_d   = K3;
                    step_d  = 2'd0;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                unique case (step_q)
                    2'd0: begin
                        acc_d  = mul + K2;
                        step_d = 2'd1;
                    end
                    2'd1: begin
                        acc_d  = mul + K1;
                        step_d = 2'd2;
                    end
                    default: begin
                        acc_d   = mul + K0 + y_ext;
                        state_d = DONE;
                    end
                endcase
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake outputs depend only on registered state
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out       = acc_q;

endmodule

// File: tb/tb_poly_horner_eval.sv
// Directed bench for poly_horner_eval at default parameters (mod 32).
// Expected results hand-computed: C2=-4->28, C1=-5->27.
module tb_poly_horner_eval;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] x;
    logic [1:0] y;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] dout;
    logic       busy;

    int checks;
    int errors;

    poly_horner_eval dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (dout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        x         = 2'd3;
        y         = 2'd3;
        #3;
        checks++;
        if ({in_ready, out_valid, busy, dout} !== {1'b1, 1'b0, 1'b0, 5'd0}) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b vld=%b busy=%b out=%0d want 1 0 0 0",
                     in_ready, out_valid, busy, dout);
        end
        tick();
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_accept: got busy=%b want 0", busy);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: got rdy=%b busy=%b want 1 0",
                     in_ready, busy);
        end
    endtask

    task automatic test_basic();
        @(negedge clk);
        in_valid  = 1'b1;
        x         = 2'd1;
        y         = 2'd0;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_accept: got busy=%b rdy=%b vld=%b want 1 0 0",
                     busy, in_ready, out_valid);
        end
        for (int e = 1; e <= 2; e++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL basic_early_valid: edge %0d got vld=%b want 0",
                         e, out_valid);
            end
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || dout !== 5'd0) begin
            errors++;
            $display("FAIL basic_result: got vld=%b out=%0d want 1 0",
                     out_valid, dout);
        end
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_return_idle: got rdy=%b vld=%b busy=%b want 1 0 0",
                     in_ready, out_valid, busy);
        end
    endtask

    task automatic test_sequence();
        logic [4:0] exp_acc [4];
        exp_acc = '{5'd8, 5'd12, 5'd19, 5'd8};
        @(negedge clk);
        in_valid  = 1'b1;
        x         = 2'd2;
        y         = 2'd1;
        out_ready = 1'b1;
        for (int e = 0; e < 4; e++) begin
            tick();
            in_valid = 1'b0;
            checks++;
            if (dout !== exp_acc[e]) begin
                errors++;
                $display("FAIL seq_acc: edge %0d got %0d want %0d",
                         e, dout, exp_acc[e]);
            end
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL seq_valid: got vld=%b want 1", out_valid);
        end
        tick();
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        in_valid  = 1'b1;
        x         = 2'd3;
        y         = 2'd3;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (out_valid !== 1'b1 || dout !== 5'd9 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold: cycle %0d got vld=%b out=%0d rdy=%b want 1 9 0",
                         c, out_valid, dout, in_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: got rdy=%b vld=%b want 1 0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        in_valid  = 1'b1;
        x         = 2'd0;
        y         = 2'd2;
        out_ready = 1'b1;
        tick();
        x = 2'd2;
        y = 2'd1;
        tick();
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b1 || dout !== 5'd3) begin
            errors++;
            $display("FAIL b2b_first: got vld=%b out=%0d want 1 3", out_valid, dout);
        end
        tick();
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_gap: got rdy=%b busy=%b want 1 0", in_ready, busy);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_accept: got busy=%b want 1", busy);
        end
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_early: got vld=%b want 0", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || dout !== 5'd8) begin
            errors++;
            $display("FAIL b2b_second: got vld=%b out=%0d want 1 8", out_valid, dout);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        in_valid  = 1'b1;
        x         = 2'd3;
        y         = 2'd0;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || dout !== 5'd0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_async: got vld=%b out=%0d rdy=%b busy=%b want 0 0 1 0",
                     out_valid, dout, in_ready, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_ghost: cycle %0d got vld=%b want 0", c, out_valid);
            end
        end
    endtask

    task automatic test_ignore_inputs();
        @(negedge clk);
        in_valid  = 1'b1;
        x         = 2'd2;
        y         = 2'd1;
        out_ready = 1'b1;
        tick();
        for (int c = 0; c < 3; c++) begin
            in_valid  = c[0];
            x         = 2'(c + 1);
            y         = 2'(3 - c);
            out_ready = (c == 2) ? 1'b0 : 1'b1;
            tick();
        end
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (out_valid !== 1'b1 || dout !== 5'd8) begin
                errors++;
                $display("FAIL ignore_result: cycle %0d got vld=%b out=%0d want 1 8",
                         c, out_valid, dout);
            end
            x = 2'(c);
            y = 2'(c + 2);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ignore_release: got rdy=%b want 1", in_ready);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_sequence();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_ignore_inputs();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
